approx_adder_pipe: RTL and testbench
====================================

Name: approx_adder_pipe

Overview:
Parametrised successor to the fixed 8-bit approximate adder. It provides configurable width and approximate-LSB count, a per-transaction exact/approximate mode, a 2-stage valid/ready pipeline, and on-line error statistics. The block sits between operand producers and accuracy-characterisation or accumulation logic. It reports each result alongside its deviation from the exact sum.

Parameters:
WIDTH, 8, operand width in bits (>=2)
APPROX_BITS, 4, number of approximate LSBs K; legal range 0..WIDTH-1; K=0 means always exact
CNT_W, 16, width of the saturating operation counter
ERR_W, 24, width of the saturating accumulated-error register

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept an operand transaction
x  input  WIDTH  operand X
y  input  WIDTH  operand Y
cin  input  1  carry-in
approx_en  input  1  1 = approximate mode, 0 = exact; sampled per transaction
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH+1  result including carry-out (MSB)
out_err  output  WIDTH+1  |exact - out_sum| for this transaction
stats_clear  input  1  synchronous clear of the statistics registers
op_count  output  CNT_W  accepted results since reset/clear, saturating
err_accum  output  ERR_W  sum of out_err over accepted results, saturating
err_max  output  WIDTH+1  maximum out_err over accepted results

Behaviour:
- Reset (reset_n low, asynchronous): all pipeline valids, out_sum, out_err, op_count, err_accum and err_max are 0. in_ready reads 1 once reset is released. Reset mid-transaction discards all in-flight data.
- Exact sum E = x + y + cin, WIDTH+1 bits.
- Approximate sum, used when approx_en=1 and K>0:
  - Bits [K-1:0] = y[K-1:0].
  - Carry into bit K = x[K-1]; cin is ignored.
  - Bits [WIDTH:K] = x[WIDTH-1:K] + y[WIDTH-1:K] + x[K-1], exact ripple.
- When approx_en=0 or K=0, out_sum = E and out_err = 0.
- out_err = |E - out_sum|, computed unsigned on WIDTH+2 bits internally, then truncated to WIDTH+1 (the value always fits).
- Pipeline:
  - Stage 1 registers x, y, cin and approx_en.
  - Stage 2 computes and registers out_sum and out_err.
  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
- Transfer occurs when valid & ready are both high on a rising edge.
- Latency: a transaction accepted at edge t produces out_valid high in the cycle after edge t+1.
- Throughput: 1 transaction per cycle with out_ready held high.
- Stall: while out_valid=1 and out_ready=0, out_sum and out_err hold stable and stage 2 holds. Stage 1 also holds if occupied, and in_ready drops then.
- in_ready depends combinationally on out_ready; there is no skid buffer.
- Statistics update only on an output transfer (out_valid & out_ready):
  - op_count += 1, saturating at 2^CNT_W-1.
  - err_accum += out_err, saturating at 2^ERR_W-1; never wraps.
  - err_max = max(err_max, out_err).
- stats_clear=1 at an edge sets all three statistics registers to 0. If an output transfer occurs on the same edge, clear wins and that transfer is not counted. The pipeline is unaffected by stats_clear.
- Simultaneous input and output transfer on one edge is legal. Data must not be lost or duplicated.

Test Plan:
1. WIDTH=8, K=4; x=0x0F, y=0x01, cin=0, approx_en=1 -> out_sum=0x011 (17), out_err=1; out_valid rises 2 cycles after acceptance.
2. x=0xFF, y=0xFF, cin=1, approx_en=1 -> out_sum=0x1FF, out_err=0. Then x=0x08, y=0x00, cin=0 -> out_sum=0x010, out_err=8. After both results are accepted: op_count=2, err_accum=8, err_max=8.
3. x=0x00, y=0x00, cin=1, approx_en=1 -> out_sum=0, out_err=1. Same operands with approx_en=0 -> out_sum=1, out_err=0.
4. Stream 10 transactions with in_valid held high and out_ready toggling 1,0,0,1,... -> outputs in order, each value held while stalled, none dropped or duplicated, in_ready=0 whenever both stages are full and out_ready=0.
5. Assert stats_clear on the same edge as an output transfer with out_err=8 -> op_count=0, err_accum=0, err_max=0 afterwards. The next transfer gives op_count=1.
6. CNT_W=2: 5 transfers give op_count=3 (saturated). Pulse reset_n low mid-stream -> out_valid=0 and all statistics 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/approx_adder_pipe.sv
// Approximate adder with per-transaction exact/approx mode and on-line error statistics.
// Latency 2 cycles, 1/cycle throughput; out_ready low stalls stage 2, then stage 1, then in_ready.
module approx_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_err,
    input  logic             stats_clear,
    output logic [CNT_W-1:0] op_count,
    output logic [ERR_W-1:0] err_accum,
    output logic [WIDTH:0]   err_max
);
    localparam int K  = APPROX_BITS;
    localparam int AW = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;
    localparam logic [AW-1:0] ACC_MAX = AW'({ERR_W{1'b1}});

    logic             s1_valid_q, s2_valid_q;
    logic             s1_adv, s2_adv, out_xfer;
    logic [WIDTH-1:0] s1_x_q, s1_y_q;
    logic             s1_cin_q, s1_apx_q;
    logic [WIDTH:0]   out_sum_q, out_err_q;
    logic [WIDTH:0]   exact_sum, approx_sum, res_sum, res_err;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] acc_q, acc_d;
    logic [WIDTH:0]   max_q, max_d;
    logic [AW-1:0]    acc_sum;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_xfer = s2_valid_q && out_ready;

    // Stage 1: operand capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_cin_q   <= 1'b0;
            s1_apx_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_x_q   <= x;
                s1_y_q   <= y;
                s1_cin_q <= cin;
                s1_apx_q <= approx_en;
            end
        end
    end

    assign exact_sum = {1'b0, s1_x_q} + {1'b0, s1_y_q} + {{WIDTH{1'b0}}, s1_cin_q};

    generate
        if (K == 0) begin : g_exact_only
            assign approx_sum = exact_sum;
        end else begin : g_approx
            logic [WIDTH-K:0] hi;
            // Low bits pass y through; x[K-1] stands in for the real carry into bit K.
            assign hi = {1'b0, s1_x_q[WIDTH-1:K]} + {1'b0, s1_y_q[WIDTH-1:K]}
                      + {{(WIDTH-K){1'b0}}, s1_x_q[K-1]};
            assign approx_sum = {hi, s1_y_q[K-1:0]};
        end
    endgenerate

    assign res_sum = s1_apx_q ? approx_sum : exact_sum;
    // Both operands are non-negative WIDTH+1 values, so the magnitude never needs the extra bit.
    assign res_err = (exact_sum >= res_sum) ? (exact_sum - res_sum) : (res_sum - exact_sum);

    // Stage 2: result register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            out_sum_q  <= '0;
            out_err_q  <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sum_q <= res_sum;
                out_err_q <= res_err;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;

    assign acc_sum = AW'(acc_q) + AW'(out_err_q);

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        max_d = max_q;
        if (stats_clear) begin
            cnt_d = '0;
            acc_d = '0;
            max_d = '0;
        end else if (out_xfer) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            acc_d = (acc_sum > ACC_MAX) ? {ERR_W{1'b1}} : acc_sum[ERR_W-1:0];
            if (out_err_q > max_q) max_d = out_err_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            max_q <= max_d;
        end
    end

    assign op_count  = cnt_q;
    assign err_accum = acc_q;
    assign err_max   = max_q;
endmodule

// File: tb/tb_approx_adder_pipe.sv
// Bench for approx_adder_pipe: directed scenarios plus randomized streams against a queue-based model.
module tb_approx_adder_pipe;
    localparam int W   = 8;
    localparam int K   = 4;
    localparam int CW  = 2;
    localparam int EW  = 7;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          cin = 1'b0;
    logic          approx_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W:0]    out_sum;
    logic [W:0]    out_err;
    logic          stats_clear = 1'b0;
    logic [CW-1:0] op_count;
    logic [EW-1:0] err_accum;
    logic [W:0]    err_max;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sum;
        int err;
        int age;
    } ent_t;
    ent_t q[$];
    int m_cnt = 0;
    int m_acc = 0;
    int m_max = 0;

    approx_adder_pipe #(.WIDTH(W), .APPROX_BITS(K), .CNT_W(CW), .ERR_W(EW)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
        .stats_clear(stats_clear), .op_count(op_count), .err_accum(err_accum), .err_max(err_max)
    );

    always #5 clock = ~clock;

    function automatic int ref_sum(int a, int b, int c, bit apx);
        if (!apx || K == 0) return a + b + c;
        return ((a >> K) + (b >> K) + ((a >> (K - 1)) & 1)) * (1 << K) + (b % (1 << K));
    endfunction

    function automatic int ref_err(int a, int b, int c, bit apx);
        int e, s;
        e = a + b + c;
        s = ref_sum(a, b, c, apx);
        return (e > s) ? e - s : s - e;
    endfunction

    // Oldest item is visible once it has survived one edge past its acceptance.
    function automatic bit exp_ov();
        return q.size() > 0 && q[0].age >= 1;
    endfunction

    function automatic bit exp_ir();
        return !(q.size() == 2 && !out_ready);
    endfunction

    task automatic set_in(input bit iv, input int xv, input int yv, input bit c, input bit a,
                          input bit ordy, input bit clr);
        in_valid    = iv;
        x           = W'(xv);
        y           = W'(yv);
        cin         = c;
        approx_en   = a;
        out_ready   = ordy;
        stats_clear = clr;
    endtask

    task automatic advance(output bit in_x, output bit out_x);
        int   e_err;
        ent_t n;
        bit   clr;
        in_x  = in_valid && exp_ir();
        out_x = exp_ov() && out_ready;
        clr   = stats_clear;
        n.sum = ref_sum(int'(x), int'(y), int'(cin), approx_en);
        n.err = ref_err(int'(x), int'(y), int'(cin), approx_en);
        n.age = 0;
        @(posedge clock);
        #1;
        e_err = 0;
        if (out_x) begin
            e_err = q[0].err;
            void'(q.pop_front());
        end
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (in_x) q.push_back(n);
        if (clr) begin
            m_cnt = 0; m_acc = 0; m_max = 0;
        end else if (out_x) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_acc = (m_acc + e_err > ERR_MAX) ? ERR_MAX : m_acc + e_err;
            m_max = (e_err > m_max) ? e_err : m_max;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", out_valid); end
        checks++; if (out_sum !== 9'd0) begin errors++; $display("FAIL reset_out_sum got %0d exp 0", out_sum); end
        checks++; if (out_err !== 9'd0) begin errors++; $display("FAIL reset_out_err got %0d exp 0", out_err); end
        checks++; if (op_count !== 2'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
        checks++; if (err_accum !== 7'd0) begin errors++; $display("FAIL reset_err_accum got %0d exp 0", err_accum); end
        checks++; if (err_max !== 9'd0) begin errors++; $display("FAIL reset_err_max got %0d exp 0", err_max); end
        @(posedge clock);
        @(negedge clock);
        #1 reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", in_ready); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_latency();
        bit ix, ox;
        set_in(1, 'h0F, 'h01, 0, 1, 1, 0);
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got %0d exp 1", in_ready); end
        advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid got %0d exp 0", out_valid); end
        advance(ix, ox);
        @(negedge clock);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %0d exp 1", out_valid); end
        checks++; if (out_sum !== 9'h011) begin errors++; $display("FAIL lat_sum got %0h exp 11", out_sum); end
        checks++; if (out_err !== 9'd1) begin errors++; $display("FAIL lat_err got %0d exp 1", out_err); end
        advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 1);
        @(negedge clock);
        advance(ix, ox);
        stats_clear = 1'b0;
    endtask

    task automatic test_carry_cases();
        bit ix, ox;
        set_in(1, 'hFF, 'hFF, 1, 1, 1, 0);
        @(negedge clock); advance(ix, ox);
        set_in(1, 'h08, 'h00, 0, 1, 1, 0);
        @(negedge clock); advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        checks++; if (out_sum !== 9'h1FF || out_err !== 9'd0) begin errors++; $display("FAIL ff_sum got %0h/%0d exp 1ff/0", out_sum, out_err); end
        advance(ix, ox);
        @(negedge clock);
        checks++; if (out_sum !== 9'h010 || out_err !== 9'd8) begin errors++; $display("FAIL x08_sum got %0h/%0d exp 10/8", out_sum, out_err); end
        advance(ix, ox);
        @(negedge clock);
        checks++; if (op_count !== 2'd2) begin errors++; $display("FAIL pair_op_count got %0d exp 2", op_count); end
        checks++; if (err_accum !== 7'd8) begin errors++; $display("FAIL pair_err_accum got %0d exp 8", err_accum); end
        checks++; if (err_max !== 9'd8) begin errors++; $display("FAIL pair_err_max got %0d exp 8", err_max); end
        advance(ix, ox);
    endtask

    task automatic test_cin_mode();
        bit ix, ox;
        set_in(1, 0, 0, 1, 1, 1, 0);
        @(negedge clock); advance(ix, ox);
        set_in(1, 0, 0, 1, 0, 1, 0);
        @(negedge clock); advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        checks++; if (out_sum !== 9'd0 || out_err !== 9'd1) begin errors++; $display("FAIL cin_approx got %0d/%0d exp 0/1", out_sum, out_err); end
        advance(ix, ox);
        @(negedge clock);
        checks++; if (out_sum !== 9'd1 || out_err !== 9'd0) begin errors++; $display("FAIL cin_exact got %0d/%0d exp 1/0", out_sum, out_err); end
        advance(ix, ox);
    endtask

    task automatic test_stall_stream();
        bit ix, ox, need_new;
        int sent, got, cx, cy, cc, ca;
        sent = 0; got = 0; need_new = 1;
        cx = 0; cy = 0; cc = 0; ca = 0;
        for (int cyc = 0; cyc < 200 && !(sent == 10 && q.size() == 0); cyc++) begin
            if (need_new) begin
                cx = $urandom_range(0, 255); cy = $urandom_range(0, 255);
                cc = $urandom_range(0, 1);   ca = $urandom_range(0, 1);
                need_new = 0;
            end
            set_in(sent < 10, cx, cy, cc[0], ca[0], (cyc % 3) == 0, 0);
            @(negedge clock);
            checks++; if (in_ready !== exp_ir()) begin errors++; $display("FAIL stall_in_ready cyc %0d got %0d exp %0d", cyc, in_ready, exp_ir()); end
            checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL stall_out_valid cyc %0d got %0d exp %0d", cyc, out_valid, exp_ov()); end
            if (exp_ov()) begin
                checks++; if (out_sum !== q[0].sum || out_err !== q[0].err) begin errors++;
                    $display("FAIL stall_data cyc %0d got %0h/%0d exp %0h/%0d", cyc, out_sum, out_err, q[0].sum, q[0].err); end
            end
            checks++; if (op_count !== m_cnt || err_accum !== m_acc || err_max !== m_max) begin errors++;
                $display("FAIL stall_stats cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", cyc, op_count, err_accum, err_max, m_cnt, m_acc, m_max); end
            advance(ix, ox);
            if (ix) begin sent++; need_new = 1; end
            if (ox) got++;
        end
        checks++; if (sent != 10 || got != 10 || q.size() != 0) begin errors++;
            $display("FAIL stall_drain sent %0d got %0d left %0d exp 10/10/0", sent, got, q.size()); end
        set_in(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_clear_collision();
        bit ix, ox;
        set_in(1, 'h08, 'h00, 0, 1, 1, 0);
        @(negedge clock); advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock); advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 1);
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_err !== 9'd8) begin errors++; $display("FAIL clr_pre got %0d/%0d exp 1/8", out_valid, out_err); end
        advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        checks++; if (op_count !== 2'd0 || err_accum !== 7'd0 || err_max !== 9'd0) begin errors++;
            $display("FAIL clr_stats got %0d/%0d/%0d exp 0/0/0", op_count, err_accum, err_max); end
        advance(ix, ox);
        set_in(1, 'h0F, 'h01, 0, 1, 1, 0);
        @(negedge clock); advance(ix, ox);
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock); advance(ix, ox);
        @(negedge clock); advance(ix, ox);
        @(negedge clock);
        checks++; if (op_count !== 2'd1 || err_accum !== 7'd1 || err_max !== 9'd1) begin errors++;
            $display("FAIL clr_next got %0d/%0d/%0d exp 1/1/1", op_count, err_accum, err_max); end
        advance(ix, ox);
    endtask

    task automatic test_saturate_reset();
        bit ix, ox;
        set_in(0, 0, 0, 0, 0, 1, 1);
        @(negedge clock); advance(ix, ox);
        for (int i = 0; i < 5; i++) begin
            set_in(1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 1, 1, 0);
            @(negedge clock); advance(ix, ox);
        end
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock); advance(ix, ox);
        @(negedge clock);
        checks++; if (op_count !== 2'd3) begin errors++; $display("FAIL sat_op_count got %0d exp 3", op_count); end
        checks++; if (err_accum !== m_acc) begin errors++; $display("FAIL sat_err_accum got %0d exp %0d", err_accum, m_acc); end
        advance(ix, ox);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 'h3C, 'hA5, 1, 1, 0, 0);
            @(negedge clock); advance(ix, ox);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0d exp 0", out_valid); end
        checks++; if (op_count !== 2'd0 || err_accum !== 7'd0 || err_max !== 9'd0) begin errors++;
            $display("FAIL rst_mid_stats got %0d/%0d/%0d exp 0/0/0", op_count, err_accum, err_max); end
        q.delete();
        m_cnt = 0; m_acc = 0; m_max = 0;
        set_in(0, 0, 0, 0, 0, 1, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_after got %0d/%0d exp 1/0", in_ready, out_valid); end
        advance(ix, ox);
    endtask

    task automatic test_random();
        bit ix, ox, hold;
        int cx, cy, cc, ca, iv;
        hold = 0; cx = 0; cy = 0; cc = 0; ca = 0; iv = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!hold) begin
                iv = ($urandom_range(0, 3) != 0);
                cx = $urandom_range(0, 255); cy = $urandom_range(0, 255);
                cc = $urandom_range(0, 1);   ca = ($urandom_range(0, 3) != 0);
            end
            set_in(iv[0], cx, cy, cc[0], ca[0], $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
            @(negedge clock);
            checks++; if (in_ready !== exp_ir()) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %0d exp %0d", cyc, in_ready, exp_ir()); end
            checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %0d exp %0d", cyc, out_valid, exp_ov()); end
            if (exp_ov()) begin
                checks++; if (out_sum !== q[0].sum || out_err !== q[0].err) begin errors++;
                    $display("FAIL rnd_data cyc %0d got %0h/%0d exp %0h/%0d", cyc, out_sum, out_err, q[0].sum, q[0].err); end
            end
            checks++; if (op_count !== m_cnt || err_accum !== m_acc || err_max !== m_max) begin errors++;
                $display("FAIL rnd_stats cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", cyc, op_count, err_accum, err_max, m_cnt, m_acc, m_max); end
            advance(ix, ox);
            hold = in_valid && !ix;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_carry_cases();
        test_cin_mode();
        test_stall_stream();
        test_clear_collision();
        test_saturate_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
